// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_pkg
//  Brief    : Shared types and constants for the iterative multiply/divide unit
//  Revision : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // One iteration per operand bit, plus one cycle to publish the result
  localparam int ITERATIONS = 32;
  localparam int LATENCY    = 33;

  // Radix-2 Booth recode of {multiplier LSB, previous LSB}
  localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD   = 2'b01;
  localparam logic [1:0] BOOTH_SUB   = 2'b10;
  localparam logic [1:0] BOOTH_HOLD1 = 2'b11;

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_if
//  Brief    : Request/result bundle between pipeline control and multdiv
//  Revision : 1.0 - initial release
// ============================================================================
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  // Pipeline side: issues requests, consumes results
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  // Unit side
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface : multdiv_if
`default_nettype wire

// File: rtl/multdiv_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_addsub
//  Brief    : 32-bit add/subtract stage shared by Booth steps, restoring
//             trial subtracts and the final quotient negation
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_addsub
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  input  wire logic             sub_i,
  output logic      [WIDTH-1:0] sum_o,
  output logic                  cout_o
);

  logic [WIDTH-1:0] b_x;

  // Subtraction as a + ~b + 1; carry-out high means "no borrow"
  always_comb begin
    b_x = b_i ^ {WIDTH{sub_i}};
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_i};
  end

endmodule : multdiv_addsub
`default_nettype wire

// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv
//  Brief    : Iterative signed 32-bit multiply (radix-2 Booth) and divide
//             (restoring, on magnitudes); fixed 33-cycle latency
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 6
) (
  input wire logic clock,
  input wire logic reset_n,
  multdiv_if.slave bus
);

  state_t               state_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 is_div_q;
  logic [WIDTH-1:0]     opnd_q;     // multiplicand (MULT) or divisor magnitude (DIV)
  logic [2*WIDTH-1:0]   prod_q;
  logic                 qm1_q;      // Booth look-behind bit
  logic [WIDTH-2:0]     rem_q;      // remainder < divisor <= 2^31, so 31 bits suffice
  logic [WIDTH-1:0]     quo_q;
  logic                 neg_q;
  logic                 div0_q;
  logic                 ovf_q;
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q;
  logic                 rdy_q;

  logic                 start;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_sub;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 add_sign;
  logic                 last_iter;
  logic                 mult_ovf;

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign a_mag     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_mag     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign last_iter = (count_q == COUNT_W'(ITERATIONS - 1));
  // Product fits in 32 bits only if bits 63:31 are a pure sign extension
  assign mult_ovf  = !((&prod_q[2*WIDTH-1:WIDTH-1]) || !(|prod_q[2*WIDTH-1:WIDTH-1]));

  // Steer the shared adder according to the current state
  always_comb begin
    add_a   = prod_q[2*WIDTH-1:WIDTH];
    add_b   = '0;
    add_sub = 1'b0;
    case (state_q)
      S_MULT: begin
        if ({prod_q[0], qm1_q} == BOOTH_ADD) begin
          add_b = opnd_q;
        end else if ({prod_q[0], qm1_q} == BOOTH_SUB) begin
          add_b   = opnd_q;
          add_sub = 1'b1;
        end
      end
      S_DIV: begin
        add_a   = {rem_q, quo_q[WIDTH-1]};
        add_b   = opnd_q;
        add_sub = 1'b1;
      end
      S_DONE: begin
        // 0 - quotient for the sign-corrected result
        add_a   = '0;
        add_b   = quo_q;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (add_sub),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // True sign of the 33-bit sum, so the Booth shift survives A = 0x80000000
  assign add_sign = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sub ^ add_cout;

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      qm1_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        // A start in any state aborts whatever was running; MULT has priority
        count_q <= '0;
        if (bus.ctrl_MULT) begin
          state_q  <= S_MULT;
          is_div_q <= 1'b0;
          opnd_q   <= bus.data_operandA;
          prod_q   <= {{WIDTH{1'b0}}, bus.data_operandB};
          qm1_q    <= 1'b0;
        end else begin
          state_q  <= S_DIV;
          is_div_q <= 1'b1;
          opnd_q   <= b_mag;
          quo_q    <= a_mag;
          rem_q    <= '0;
          neg_q    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          div0_q   <= (bus.data_operandB == '0);
          ovf_q    <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.data_operandB == {WIDTH{1'b1}});
        end
      end else begin
        case (state_q)
          S_MULT: begin
            prod_q  <= {add_sign, add_sum, prod_q[WIDTH-1:1]};
            qm1_q   <= prod_q[0];
            count_q <= count_q + COUNT_W'(1);
            if (last_iter) state_q <= S_DONE;
          end
          S_DIV: begin
            rem_q   <= add_cout ? add_sum[WIDTH-2:0] : {rem_q[WIDTH-3:0], quo_q[WIDTH-1]};
            quo_q   <= {quo_q[WIDTH-2:0], add_cout};
            count_q <= count_q + COUNT_W'(1);
            if (last_iter) state_q <= S_DONE;
          end
          S_DONE: begin
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
            if (!is_div_q) begin
              result_q <= prod_q[WIDTH-1:0];
              exc_q    <= mult_ovf;
            end else if (div0_q) begin
              result_q <= '0;
              exc_q    <= 1'b1;
            end else begin
              result_q <= neg_q ? add_sum : quo_q;
              exc_q    <= ovf_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule : multdiv
`default_nettype wire

// File: tb/tb_multdiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv
//  Brief    : Directed self-checking bench for multdiv
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv;
  import multdiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  multdiv_if bus ();

  multdiv #(.WIDTH(32), .COUNT_W(6)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mul;
    logic        dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a one-cycle start; operands are scrambled right after the edge
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  // Observe n edges after a start; report first RDY cycle and pulse count
  task automatic watch(input int n, output int first, output int cnt,
                       output logic [31:0] res, output logic exc);
    first = 0;
    cnt   = 0;
    res   = '0;
    exc   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first = k;
          res   = bus.data_result;
          exc   = bus.data_exception;
        end
      end
    end
  endtask

  initial begin
    int          first;
    int          cnt;
    logic [31:0] res;
    logic        exc;

    vecs[0]  = '{1'b1, 1'b0, 32'd7,         32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h00010000,  32'h00010000, 32'h00000000, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h80000000,  32'd1,        32'h80000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd100,       32'd7,        32'd14,       1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'd5,         32'd0,        32'd0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd3,         32'd3,        32'd9,        1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'd6,         32'd7,        32'd42,       1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'd7,         32'd100,      32'd0,        1'b0};

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc",    32'(bus.data_exception), 32'd0);
    check("reset_rdy",    32'(bus.data_resultRDY), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].mul, vecs[i].dv, vecs[i].a, vecs[i].b);
      watch(LATENCY + 7, first, cnt, res, exc);
      check($sformatf("v%0d_rdy_cycle", i), 32'(first), 32'(LATENCY));
      check($sformatf("v%0d_rdy_count", i), 32'(cnt), 32'd1);
      check($sformatf("v%0d_result", i), res, vecs[i].res);
      check($sformatf("v%0d_exc", i), 32'(exc), 32'(vecs[i].exc));
      check($sformatf("v%0d_hold", i), bus.data_result, vecs[i].res);
    end

    // MULT 3x4 aborted by DIV 20/4 at cycle 10
    issue(1'b1, 1'b0, 32'd3, 32'd4);
    watch(9, first, cnt, res, exc);
    check("abort_mult_rdy", 32'(cnt), 32'd0);
    issue(1'b0, 1'b1, 32'd20, 32'd4);
    watch(LATENCY + 7, first, cnt, res, exc);
    check("abort_div_cycle", 32'(first), 32'(LATENCY));
    check("abort_div_count", 32'(cnt), 32'd1);
    check("abort_div_result", res, 32'd5);

    // Restart on the DONE cycle suppresses the pending RDY
    issue(1'b1, 1'b0, 32'd2, 32'd3);
    watch(ITERATIONS, first, cnt, res, exc);
    check("done_restart_pre", 32'(cnt), 32'd0);
    issue(1'b0, 1'b1, 32'd9, 32'd3);
    watch(LATENCY + 7, first, cnt, res, exc);
    check("done_restart_cycle", 32'(first), 32'(LATENCY));
    check("done_restart_count", 32'(cnt), 32'd1);
    check("done_restart_result", res, 32'd3);

    // Asynchronous reset at cycle 5 of a MULT
    issue(1'b1, 1'b0, 32'd3, 32'd5);
    watch(4, first, cnt, res, exc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_result", bus.data_result, 32'd0);
    check("midreset_exc",    32'(bus.data_exception), 32'd0);
    check("midreset_rdy",    32'(bus.data_resultRDY), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch(LATENCY + 7, first, cnt, res, exc);
    check("midreset_no_rdy", 32'(cnt), 32'd0);
    issue(1'b1, 1'b0, 32'd2, 32'd2);
    watch(LATENCY + 7, first, cnt, res, exc);
    check("post_reset_cycle", 32'(first), 32'(LATENCY));
    check("post_reset_result", res, 32'd4);
    check("post_reset_exc", 32'(exc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multdiv
`default_nettype wire
